// File: rtl/sevenseg_countdown_display.sv
// MM:SS BCD countdown timer driving a 4-digit multiplexed common-anode display.
// Consumes a 1 Hz tick and a digit-scan strobe; start toggles run/pause, clear reloads.
module sevenseg_countdown_display #(
  parameter int START_MIN = 1,
  parameter int START_SEC = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       scan_en,
  input  logic       start,
  input  logic       clear,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       running,
  output logic       time_up
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] P_M_T = 4'(START_MIN / 10);
  localparam logic [3:0] P_M_O = 4'(START_MIN % 10);
  localparam logic [3:0] P_S_T = 4'(START_SEC / 10);
  localparam logic [3:0] P_S_O = 4'(START_SEC % 10);

  state_t     r_state, w_state_next;
  logic [3:0] r_m_t, r_m_o, r_s_t, r_s_o;
  logic [3:0] w_m_t_next, w_m_o_next, w_s_t_next, w_s_o_next;
  logic [3:0] w_dec_m_t, w_dec_m_o, w_dec_s_t, w_dec_s_o;
  logic       r_blink, w_blink_next;
  logic       r_time_up, w_time_up_next;
  logic       r_running;
  logic       w_is_zero, w_is_one;

  logic [1:0] r_idx;
  logic [3:0] r_an;
  logic [6:0] r_seg;
  logic       r_dp;
  logic [3:0] w_an_sel;
  logic [3:0] w_digit;
  logic [6:0] w_seg_dec;
  logic       w_blank;

  assign w_is_zero = (r_m_t == 4'd0) && (r_m_o == 4'd0) && (r_s_t == 4'd0) && (r_s_o == 4'd0);
  assign w_is_one  = (r_m_t == 4'd0) && (r_m_o == 4'd0) && (r_s_t == 4'd0) && (r_s_o == 4'd1);

  // Cascaded BCD borrow: each digit rolls over only when every lower digit is zero.
  always_comb begin
    w_dec_m_t = r_m_t;
    w_dec_m_o = r_m_o;
    w_dec_s_t = r_s_t;
    w_dec_s_o = r_s_o;
    if (r_s_o != 4'd0) begin
      w_dec_s_o = r_s_o - 4'd1;
    end else begin
      w_dec_s_o = 4'd9;
      if (r_s_t != 4'd0) begin
        w_dec_s_t = r_s_t - 4'd1;
      end else begin
        w_dec_s_t = 4'd5;
        if (r_m_o != 4'd0) begin
          w_dec_m_o = r_m_o - 4'd1;
        end else begin
          w_dec_m_o = 4'd9;
          w_dec_m_t = r_m_t - 4'd1;
        end
      end
    end
  end

  // Next-state logic: clear beats start, start beats tick.
  always_comb begin
    w_state_next   = r_state;
    w_m_t_next     = r_m_t;
    w_m_o_next     = r_m_o;
    w_s_t_next     = r_s_t;
    w_s_o_next     = r_s_o;
    w_blink_next   = r_blink;
    w_time_up_next = 1'b0;
    if (clear) begin
      w_state_next = S_IDLE;
      w_m_t_next   = P_M_T;
      w_m_o_next   = P_M_O;
      w_s_t_next   = P_S_T;
      w_s_o_next   = P_S_O;
      w_blink_next = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_is_zero) begin
              w_state_next   = S_DONE;
              w_time_up_next = 1'b1;
            end else begin
              w_state_next = S_RUN;
            end
          end
        end
        S_RUN: begin
          if (start) begin
            w_state_next = S_PAUSED;
          end else if (tick_1hz && !w_is_zero) begin
            w_m_t_next = w_dec_m_t;
            w_m_o_next = w_dec_m_o;
            w_s_t_next = w_dec_s_t;
            w_s_o_next = w_dec_s_o;
            if (w_is_one) begin
              w_state_next   = S_DONE;
              w_time_up_next = 1'b1;
            end
          end
        end
        S_PAUSED: begin
          if (start) begin
            w_state_next = S_RUN;
          end
        end
        S_DONE: begin
          if (tick_1hz) begin
            w_blink_next = ~r_blink;
          end
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end
  end

  // State, digit and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_m_t     <= P_M_T;
      r_m_o     <= P_M_O;
      r_s_t     <= P_S_T;
      r_s_o     <= P_S_O;
      r_blink   <= 1'b0;
      r_time_up <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_m_t     <= w_m_t_next;
      r_m_o     <= w_m_o_next;
      r_s_t     <= w_s_t_next;
      r_s_o     <= w_s_o_next;
      r_blink   <= w_blink_next;
      r_time_up <= w_time_up_next;
      r_running <= (w_state_next == S_RUN);
    end
  end

  // One-hot-low anode pattern for the current scan index.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_an
      assign w_an_sel[gi] = (r_idx != 2'(gi));
    end
  endgenerate

  // Digit selected by the scan index: 0 = seconds ones ... 3 = minutes tens.
  always_comb begin
    w_digit = r_s_o;
    case (r_idx)
      2'd0:    w_digit = r_s_o;
      2'd1:    w_digit = r_s_t;
      2'd2:    w_digit = r_m_o;
      default: w_digit = r_m_t;
    endcase
  end

  // Active-low segment decode {g,f,e,d,c,b,a}; non-BCD values blank.
  always_comb begin
    w_seg_dec = 7'b1111111;
    case (w_digit)
      4'd0:    w_seg_dec = 7'b1000000;
      4'd1:    w_seg_dec = 7'b1111001;
      4'd2:    w_seg_dec = 7'b0100100;
      4'd3:    w_seg_dec = 7'b0110000;
      4'd4:    w_seg_dec = 7'b0011001;
      4'd5:    w_seg_dec = 7'b0010010;
      4'd6:    w_seg_dec = 7'b0000010;
      4'd7:    w_seg_dec = 7'b1111000;
      4'd8:    w_seg_dec = 7'b0000000;
      4'd9:    w_seg_dec = 7'b0010000;
      default: w_seg_dec = 7'b1111111;
    endcase
  end

  assign w_blank = (r_state == S_DONE) && r_blink;

  // Scanner: latch the current digit onto the pins and advance the index on each scan strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= 2'd0;
      r_an  <= 4'b1111;
      r_seg <= 7'b1111111;
      r_dp  <= 1'b1;
    end else if (scan_en) begin
      r_idx <= r_idx + 2'd1;
      r_an  <= w_an_sel;
      r_seg <= w_blank ? 7'b1111111 : w_seg_dec;
      r_dp  <= w_blank ? 1'b1 : (r_idx != 2'd2);
    end
  end

  assign an      = r_an;
  assign seg     = r_seg;
  assign dp      = r_dp;
  assign running = r_running;
  assign time_up = r_time_up;

endmodule

// File: tb/tb_sevenseg_countdown_display.sv
// Bench for sevenseg_countdown_display: four instances with different presets share
// one stimulus stream and are checked against a seconds-based reference model.
module tb_sevenseg_countdown_display;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, tick_1hz, scan_en, start, clear;
  logic [3:0] an_o  [4];
  logic [6:0] seg_o [4];
  logic       dp_o  [4];
  logic       run_o [4];
  logic       tu_o  [4];

  localparam int PM [4] = '{1, 0, 10, 0};
  localparam int PS [4] = '{30, 3, 0, 0};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dut
      sevenseg_countdown_display #(.START_MIN(PM[gi]), .START_SEC(PS[gi])) u_dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .scan_en(scan_en),
        .start(start), .clear(clear),
        .an(an_o[gi]), .seg(seg_o[gi]), .dp(dp_o[gi]),
        .running(run_o[gi]), .time_up(tu_o[gi])
      );
    end
  endgenerate

  int n_checks = 0;
  int n_errors = 0;

  logic [6:0] dec_tbl [10];

  // Reference model: remaining time kept as plain seconds; state 0 idle,1 run,2 paused,3 done.
  int         m_state [4];
  int         m_secs  [4];
  int         m_blink [4];
  int         m_idx   [4];
  logic [3:0] m_an    [4];
  logic [6:0] m_seg   [4];
  logic       m_dp    [4];
  logic       m_run   [4];
  logic       m_tu    [4];

  typedef struct {
    bit         scan;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } vec_t;
  vec_t t4 [5];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int digit_of(input int secs, input int idx);
    case (idx)
      0:       return (secs % 60) % 10;
      1:       return (secs % 60) / 10;
      2:       return (secs / 60) % 10;
      default: return (secs / 60) / 10;
    endcase
  endfunction

  task automatic model_reset(input int k);
    m_state[k] = 0;
    m_secs[k]  = PM[k] * 60 + PS[k];
    m_blink[k] = 0;
    m_idx[k]   = 0;
    m_an[k]    = 4'b1111;
    m_seg[k]   = 7'b1111111;
    m_dp[k]    = 1'b1;
    m_run[k]   = 1'b0;
    m_tu[k]    = 1'b0;
  endtask

  task automatic model_step();
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        model_reset(k);
      end else begin
        if (scan_en) begin
          bit blank;
          blank    = (m_state[k] == 3) && (m_blink[k] == 1);
          m_an[k]  = ~(4'b0001 << m_idx[k]);
          m_seg[k] = blank ? 7'b1111111 : dec_tbl[digit_of(m_secs[k], m_idx[k])];
          m_dp[k]  = blank ? 1'b1 : (m_idx[k] != 2);
          m_idx[k] = (m_idx[k] + 1) % 4;
        end
        m_tu[k] = 1'b0;
        if (clear) begin
          m_state[k] = 0;
          m_secs[k]  = PM[k] * 60 + PS[k];
          m_blink[k] = 0;
        end else begin
          case (m_state[k])
            0: if (start) begin
              if (m_secs[k] == 0) begin m_state[k] = 3; m_tu[k] = 1'b1; end
              else m_state[k] = 1;
            end
            1: if (start) m_state[k] = 2;
               else if (tick_1hz && m_secs[k] > 0) begin
                 m_secs[k]--;
                 if (m_secs[k] == 0) begin m_state[k] = 3; m_tu[k] = 1'b1; end
               end
            2: if (start) m_state[k] = 1;
            default: if (tick_1hz) m_blink[k] = 1 - m_blink[k];
          endcase
        end
        m_run[k] = (m_state[k] == 1);
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("model u%0d an", k),      int'(an_o[k]),  int'(m_an[k]));
      chk($sformatf("model u%0d seg", k),     int'(seg_o[k]), int'(m_seg[k]));
      chk($sformatf("model u%0d dp", k),      int'(dp_o[k]),  int'(m_dp[k]));
      chk($sformatf("model u%0d running", k), int'(run_o[k]), int'(m_run[k]));
      chk($sformatf("model u%0d time_up", k), int'(tu_o[k]),  int'(m_tu[k]));
    end
  endtask

  // One clock: drive inputs, take the edge, sample 1 ns later, advance and compare the model.
  task automatic step(input bit t, input bit sc, input bit st, input bit cl);
    tick_1hz = t; scan_en = sc; start = st; clear = cl;
    @(posedge clk);
    #1;
    model_step();
    compare_all();
    $display("step t=%0t tick=%0b scan=%0b start=%0b clear=%0b u0 an=%b seg=%b run=%0b tu=%0b",
             $time, t, sc, st, cl, an_o[0], seg_o[0], run_o[0], tu_o[0]);
    tick_1hz = 1'b0; scan_en = 1'b0; start = 1'b0; clear = 1'b0;
  endtask

  // Scan all four digits of instance k and compare against an expected MM:SS.
  task automatic check_disp(input int k, input int mm, input int ss, input string tag);
    for (int i = 0; i < 4; i++) begin
      int p;
      p = m_idx[k];
      step(1'b0, 1'b1, 1'b0, 1'b0);
      chk($sformatf("%s digit%0d", tag, p), int'(seg_o[k]), int'(dec_tbl[digit_of(mm * 60 + ss, p)]));
    end
  endtask

  initial begin
    dec_tbl[0] = 7'b1000000; dec_tbl[1] = 7'b1111001; dec_tbl[2] = 7'b0100100;
    dec_tbl[3] = 7'b0110000; dec_tbl[4] = 7'b0011001; dec_tbl[5] = 7'b0010010;
    dec_tbl[6] = 7'b0000010; dec_tbl[7] = 7'b1111000; dec_tbl[8] = 7'b0000000;
    dec_tbl[9] = 7'b0010000;
    t4[0] = '{1'b1, 4'b1110, 7'b1000000, 1'b1};
    t4[1] = '{1'b1, 4'b1101, 7'b0110000, 1'b1};
    t4[2] = '{1'b1, 4'b1011, 7'b1111001, 1'b0};
    t4[3] = '{1'b1, 4'b0111, 7'b1000000, 1'b1};
    t4[4] = '{1'b1, 4'b1110, 7'b1000000, 1'b1};

    rst = 1'b1; tick_1hz = 1'b0; scan_en = 1'b0; start = 1'b0; clear = 1'b0;
    for (int k = 0; k < 4; k++) model_reset(k);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset an", int'(an_o[0]), 4'hF);
    chk("reset seg", int'(seg_o[0]), 7'h7F);
    chk("reset dp", int'(dp_o[0]), 1);
    chk("reset running", int'(run_o[0]), 0);
    chk("reset time_up", int'(tu_o[0]), 0);
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Scanner walk over the 01:30 preset, including the wrap back to index 0.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, t4[i].scan, 1'b0, 1'b0);
      chk($sformatf("scan%0d an", i),  int'(an_o[0]),  int'(t4[i].an));
      chk($sformatf("scan%0d seg", i), int'(seg_o[0]), int'(t4[i].seg));
      chk($sformatf("scan%0d dp", i),  int'(dp_o[0]),  int'(t4[i].dp));
    end

    // Countdown to zero from 00:03, BCD borrow from 10:00, start at 00:00.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("start u0 running", int'(run_o[0]), 1);
    chk("start u1 running", int'(run_o[1]), 1);
    chk("zero-start u3 time_up", int'(tu_o[3]), 1);
    chk("zero-start u3 running", int'(run_o[3]), 0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check_disp(1, 0, 2, "u1 00:02");
    check_disp(2, 9, 59, "u2 09:59");
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check_disp(1, 0, 1, "u1 00:01");
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("u1 time_up after last tick", int'(tu_o[1]), 1);
    chk("u1 running at done", int'(run_o[1]), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("u1 time_up one cycle", int'(tu_o[1]), 0);
    check_disp(1, 0, 0, "u1 00:00");
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check_disp(1, 0, 0, "u1 held 00:00");
    for (int i = 0; i < 56; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    check_disp(2, 8, 59, "u2 08:59");
    check_disp(0, 0, 29, "u0 00:29");

    // Start and tick together: pause wins, digits hold, ticks ignored while paused.
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("pause u0 running", int'(run_o[0]), 0);
    check_disp(0, 0, 29, "u0 paused");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    check_disp(0, 0, 29, "u0 paused ticks");
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("resume u0 running", int'(run_o[0]), 1);

    // Blink in DONE, then clear.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      chk($sformatf("blink u1 seg%0d", i), int'(seg_o[1]), 7'h7F);
      chk($sformatf("blink u1 dp%0d", i),  int'(dp_o[1]), 1);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check_disp(1, 0, 0, "u1 unblank");
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("clear u1 time_up", int'(tu_o[1]), 0);
    chk("clear u0 running", int'(run_o[0]), 0);
    check_disp(0, 1, 30, "u0 cleared 01:30");
    check_disp(1, 0, 3, "u1 cleared 00:03");

    // Asynchronous reset while running at 00:47.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 43; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    check_disp(0, 0, 47, "u0 00:47");
    rst = 1'b1;
    #2;
    chk("async rst an", int'(an_o[0]), 4'hF);
    chk("async rst seg", int'(seg_o[0]), 7'h7F);
    chk("async rst dp", int'(dp_o[0]), 1);
    chk("async rst running", int'(run_o[0]), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check_disp(0, 1, 30, "u0 after rst 01:30");
    chk("after rst running", int'(run_o[0]), 0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      step($urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 39) == 0, $urandom_range(0, 199) == 0);
      rst = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
